// File: rtl/cpu54_pkg.sv
// Shared CPU54 definitions: multiply/divide op encodings and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu54_pkg;

    // op[1] selects divide, op[0] selects signed arithmetic
    localparam logic [1:0] MD_OP_MULTU = 2'b00;
    localparam logic [1:0] MD_OP_MULT  = 2'b01;
    localparam logic [1:0] MD_OP_DIVU  = 2'b10;
    localparam logic [1:0] MD_OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_OP_DIVU) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/cpu54_muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one 2*WIDTH register.
// Latency: one bit per step; results are combinational from the settled register.
// Backpressure: none; load and step are driven by the controlling FSM.
module cpu54_muldiv_datapath
    import cpu54_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock_in,
    input  logic             reset_signal_n,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_div_zero
);

    // acc holds {upper product, lower product/multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   a_raw;     // unmodified dividend for the divide-by-zero result
    logic               is_div_q;
    logic               is_signed_q;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;

    logic               in_sign_a;
    logic               in_sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes: only signed ops strip the sign
    always_comb begin
        in_sign_a = md_is_signed(op) && src_a[WIDTH-1];
        in_sign_b = md_is_signed(op) && src_b[WIDTH-1];
        a_mag     = in_sign_a ? -src_a : src_a;
        b_mag     = in_sign_b ? -src_b : src_b;
    end

    // One iteration: add-then-shift-right for multiply, shift-then-trial-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        acc_step  = acc;
        if (!is_div_q) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Operand latch on start, then one iteration per RUN cycle
    always_ff @(posedge clock_in or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            acc         <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
        end else if (load) begin
            is_div_q    <= md_is_div(op);
            is_signed_q <= md_is_signed(op);
            sign_a      <= in_sign_a;
            sign_b      <= in_sign_b;
            a_raw       <= src_a;
            b_zero      <= (src_b == '0);
            opnd        <= md_is_div(op) ? b_mag : a_mag;
            acc         <= {{WIDTH{1'b0}}, (md_is_div(op) ? a_mag : b_mag)};
        end else if (step) begin
            acc         <= acc_step;
        end
    end

    // Sign correction and divide-by-zero override of the final result
    always_comb begin
        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        prod_fix = (is_signed_q && (sign_a ^ sign_b)) ? -acc : acc;
        quo_fix  = (is_signed_q && (sign_a ^ sign_b)) ? -quo : quo;
        rem_fix  = (is_signed_q && sign_a) ? -rem : rem;
        res_div_zero = is_div_q && b_zero;
        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi = a_raw;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

endmodule

// File: rtl/cpu54_muldiv_unit.sv
// CPU54 multicycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Latency: start accepted at edge E, done pulses in the cycle after edge E+WIDTH+1.
// Backpressure: start and HI/LO writes are ignored while busy; done is a bare pulse.
module cpu54_muldiv_unit
    import cpu54_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock_in,
    input  logic             reset_signal_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t        state;
    logic [CW-1:0]    count;
    logic             start_accept;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_div_zero;

    assign start_accept = (state == MD_IDLE) && start;
    assign step         = (state == MD_RUN);
    assign finish       = (state == MD_FIX) && !cancel;

    // Busy spans RUN and FIX, so it drops at the same edge that raises done
    assign busy = (state != MD_IDLE);

    cpu54_muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock_in       (clock_in),
        .reset_signal_n (reset_signal_n),
        .load           (start_accept),
        .step           (step),
        .op             (op),
        .src_a          (src_a),
        .src_b          (src_b),
        .res_hi         (res_hi),
        .res_lo         (res_lo),
        .res_div_zero   (res_div_zero)
    );

    // Sequencer: IDLE -> RUN for WIDTH iterations -> FIX -> IDLE, cancel aborts anywhere busy
    always_ff @(posedge clock_in or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        count <= '0;
                        state <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (cancel) begin
                        state <= MD_IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    // HI/LO: direct writes only in IDLE, result load only on an uncancelled FIX
    always_ff @(posedge clock_in or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= finish;
            div_zero <= finish && res_div_zero;
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == MD_IDLE) begin
                if (hi_we) begin
                    hi <= wdata;
                end
                if (lo_we) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule
